// File: rtl/argmax_unit.sv
// argmax_unit: scans the final-layer logit memory through its combinational
// read port and registers the index and value of the largest signed logit.
// The outputs change only when a scan completes, and done pulses for one
// cycle at that point.
module argmax_unit #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int IDX_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic                  busy,
    output logic                  done,
    output logic [IDX_WIDTH-1:0]  max_index,
    output logic [DATA_WIDTH-1:0] max_value
);

    localparam logic [IDX_WIDTH-1:0] LAST_K = IDX_WIDTH'(NUM_CLASSES - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t                 state_q;
    logic [IDX_WIDTH-1:0]   k_q;
    logic [DATA_WIDTH-1:0]  cur_val_q;
    logic [IDX_WIDTH-1:0]   cur_idx_q;
    logic [ADDR_WIDTH-1:0]  read_addr_q;
    logic                   busy_q;
    logic                   done_q;
    logic [IDX_WIDTH-1:0]   max_index_q;
    logic [DATA_WIDTH-1:0]  max_value_q;

    logic                   take_d;
    logic [DATA_WIDTH-1:0]  win_val_d;
    logic [IDX_WIDTH-1:0]   win_idx_d;
    logic [IDX_WIDTH-1:0]   k_next_d;

    // Running-max candidate: the first entry always loads; later entries
    // load only when strictly greater (signed), so ties keep the lower index.
    always_comb begin
        take_d    = (k_q == '0) || ($signed(read_data) > $signed(cur_val_q));
        win_val_d = take_d ? read_data : cur_val_q;
        win_idx_d = take_d ? k_q : cur_idx_q;
        k_next_d  = k_q + 1'b1;
    end

    // Scan FSM. read_addr is registered, so it is loaded one step ahead with
    // the address of the entry that will be sampled at the next edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            k_q         <= '0;
            cur_val_q   <= '0;
            cur_idx_q   <= '0;
            read_addr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            max_index_q <= '0;
            max_value_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    read_addr_q <= '0;
                    busy_q      <= 1'b0;
                    if (start) begin
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    cur_val_q <= win_val_d;
                    cur_idx_q <= win_idx_d;
                    if (k_q == LAST_K) begin
                        max_value_q <= win_val_d;
                        max_index_q <= win_idx_d;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        read_addr_q <= '0;
                        k_q         <= '0;
                        state_q     <= IDLE;
                    end else begin
                        k_q         <= k_next_d;
                        read_addr_q <= ADDR_WIDTH'(k_next_d);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign read_addr = read_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign max_index = max_index_q;
    assign max_value = max_value_q;

endmodule

// File: tb/tb_argmax_unit.sv
// tb_argmax_unit: directed-vector bench for argmax_unit with a behavioural
// 10-entry logit memory driving the combinational read port.
module tb_argmax_unit;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [15:0] read_addr;
    logic [31:0] read_data;
    logic        busy;
    logic        done;
    logic [3:0]  max_index;
    logic [31:0] max_value;

    logic [31:0] mem [10];

    int checks;
    int failures;
    int n;

    argmax_unit #(
        .NUM_CLASSES(10),
        .DATA_WIDTH (32),
        .ADDR_WIDTH (16),
        .IDX_WIDTH  (4)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .read_addr(read_addr),
        .read_data(read_data),
        .busy     (busy),
        .done     (done),
        .max_index(max_index),
        .max_value(max_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational memory read port
    always_comb begin
        read_data = '0;
        if (read_addr < 16'd10) read_data = mem[read_addr[3:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge, then wait (bounded) for done; n = cycles from start edge
    task automatic run_scan();
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        chk("latency", 32'(n), 32'd10);
    endtask

    task automatic load_distinct();
        mem = '{5, -3, 17, 2, 9, 0, 16, -100, 4, 1};
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        resetn   = 1'b0;
        start    = 1'b0;
        load_distinct();

        // Reset state
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_idx", 32'(max_index), 32'd0);
        chk("rst_val", max_value, 32'd0);
        chk("rst_addr", 32'(read_addr), 32'd0);
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_no_done", 32'(done), 32'd0);
            chk("idle_addr", 32'(read_addr), 32'd0);
        end

        // Distinct values: address sequence, busy window, done timing
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("d_addr", 32'(read_addr), 32'(i));
            chk("d_busy", 32'(busy), 32'd1);
            chk("d_nodone", 32'(done), 32'd0);
            chk("d_hold_idx", 32'(max_index), 32'd0);
            step();
        end
        chk("d_done", 32'(done), 32'd1);
        chk("d_busy_end", 32'(busy), 32'd0);
        chk("d_idx", 32'(max_index), 32'd2);
        chk("d_val", max_value, 32'd17);
        step();
        chk("d_done_clr", 32'(done), 32'd0);

        // Output hold: memory changes without start
        mem[6] = 32'd1000;
        for (int i = 0; i < 4; i++) step();
        chk("hold_idx", 32'(max_index), 32'd2);
        chk("hold_val", max_value, 32'd17);
        chk("hold_done", 32'(done), 32'd0);
        run_scan();
        chk("hold_new_idx", 32'(max_index), 32'd6);
        chk("hold_new_val", max_value, 32'd1000);
        step();

        // Ties: equal maxima keep the lower index
        for (int i = 0; i < 10; i++) mem[i] = -32'sd7;
        mem[3] = 32'h7FFF_FFFF;
        mem[8] = 32'h7FFF_FFFF;
        run_scan();
        chk("tie_idx", 32'(max_index), 32'd3);
        chk("tie_val", max_value, 32'h7FFF_FFFF);
        step();

        // Signedness: all negative, -1 at the last entry is largest
        mem = '{-5, -10, -11, -12, -13, -14, -15, -16, -17, -1};
        run_scan();
        chk("neg_idx", 32'(max_index), 32'd9);
        chk("neg_val", max_value, 32'hFFFF_FFFF);
        step();

        // Reset mid-scan
        load_distinct();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("mid_addr", 32'(read_addr), 32'd5);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_idx", 32'(max_index), 32'd0);
        chk("mid_val", max_value, 32'd0);
        chk("mid_addr0", 32'(read_addr), 32'd0);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) n++;
            step();
        end
        chk("mid_no_done", 32'(n), 32'd0);
        run_scan();
        chk("mid_rerun_idx", 32'(max_index), 32'd2);
        chk("mid_rerun_val", max_value, 32'd17);
        step();

        // Start held high: no restart, back-to-back scan from the done cycle
        mem[6] = 32'd20;
        start = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            chk("bb1_addr", 32'(read_addr), 32'(i));
            chk("bb1_nodone", 32'(done), 32'd0);
            step();
        end
        chk("bb1_done", 32'(done), 32'd1);
        chk("bb1_idx", 32'(max_index), 32'd6);
        step();
        chk("bb2_busy", 32'(busy), 32'd1);
        chk("bb2_done_clr", 32'(done), 32'd0);
        for (int i = 0; i < 10; i++) begin
            chk("bb2_addr", 32'(read_addr), 32'(i));
            chk("bb2_nodone", 32'(done), 32'd0);
            step();
        end
        chk("bb2_done", 32'(done), 32'd1);
        chk("bb2_val", max_value, 32'd20);
        start = 1'b0;
        step();
        chk("bb_idle_busy", 32'(busy), 32'd0);
        chk("bb_idle_done", 32'(done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
